keypad_entry: RTL

Front-end stage of the lock datapath. Takes a raw keypad scan (key code plus press level), synchronises and debounces it, and assembles NUM_DIGITS decimal digits into a packed code word. On ENTER it presents that code word to the downstream comparator with a valid/ready handshake. It also handles CLEAR, inactivity timeout and malformed entries.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/key_debounce.sv | 72 +++++++
 rtl/keypad_entry.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry front-end.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR_DEF = 4'hA;
  localparam logic [3:0] KEY_ENTER_DEF = 4'hB;
  localparam logic [3:0] KEY_DIGIT_MIN = 4'h0;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return (key >= KEY_DIGIT_MIN) && (key <= KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw keypad scan, debounces the press level and emits a
// one-cycle event with the latched key code on each accepted press.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code_i,
  input  logic       key_press_i,
  output logic       key_event_o,
  output logic [3:0] key_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      press_sync_q;
  logic [3:0]      code_sync1_q;
  logic [3:0]      code_sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            event_q;
  logic [3:0]      key_q;
  logic            rise;

  // Counter only advances while the synchronised press disagrees with the
  // accepted level; any agreement (a bounce back) restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (press_sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = press_sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise = level_q & ~level_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_sync_q <= 2'b00;
      code_sync1_q <= 4'h0;
      code_sync2_q <= 4'h0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_dly_q  <= 1'b0;
      event_q      <= 1'b0;
      key_q        <= 4'h0;
    end else begin
      press_sync_q <= {press_sync_q[0], key_press_i};
      code_sync1_q <= key_code_i;
      code_sync2_q <= code_sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_dly_q  <= level_q;
      event_q      <= rise;
      if (rise) begin
        key_q <= code_sync2_q;
      end
    end
  end

  assign key_event_o = event_q;
  assign key_o       = key_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front-end: collects NUM_DIGITS decimal digits into a packed
// code word and offers it downstream with a valid/ready handshake on ENTER.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int         NUM_DIGITS      = 4,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES  = 1000,
  parameter logic [3:0] KEY_CLEAR       = KEY_CLEAR_DEF,
  parameter logic [3:0] KEY_ENTER       = KEY_ENTER_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        key_code,
  input  logic                              key_press,
  output logic [4*NUM_DIGITS-1:0]           code,
  output logic                              code_valid,
  input  logic                              code_ready,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              entry_error,
  output logic                              busy
);

  localparam int CODE_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;
  logic              key_event;
  logic [3:0]        key;
  logic              ev_digit;
  logic              ev_clear;
  logic              ev_enter;

  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic [TMR_W-1:0]  timer_q;
  logic              err_q;
  logic              valid_q;
  logic              busy_q;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n_int),
    .key_code_i  (key_code),
    .key_press_i (key_press),
    .key_event_o (key_event),
    .key_o       (key)
  );

  assign ev_digit = key_event && is_digit(key);
  assign ev_clear = key_event && (key == KEY_CLEAR);
  assign ev_enter = key_event && (key == KEY_ENTER);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      timer_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ev_digit) begin
            code_q  <= CODE_W'(key);
            count_q <= CNT_W'(1);
            ovf_q   <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (ev_digit) begin
            timer_q <= '0;
            if (count_q == CNT_FULL) begin
              ovf_q <= 1'b1;
            end else begin
              code_q  <= (code_q << 4) | CODE_W'(key);
              count_q <= count_q + CNT_W'(1);
            end
          end else if (ev_clear) begin
            code_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (ev_enter && (count_q == CNT_FULL) && !ovf_q) begin
            timer_q <= '0;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else if (ev_enter || (timer_q == TMR_LAST)) begin
            // Short/overflowed ENTER or inactivity: discard with an error.
            err_q   <= 1'b1;
            code_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_HOLD: begin
          if (code_ready) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          code_q  <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign code        = code_q;
  assign code_valid  = valid_q;
  assign digit_count = count_q;
  assign entry_error = err_q;
  assign busy        = busy_q;

endmodule
